// File: rtl/ps2_rx_byte_framer.sv
// PS/2 device-to-host byte receiver.
// Synchronizes the raw PS/2 lines and debounces the PS/2 clock. It deframes
// start/8 data/odd parity/stop frames and reports each byte with a one-cycle
// strobe. Bad frames are reported with their own one-cycle error strobes.
module ps2_rx_byte_framer #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       i_driver_clk,
   input  logic       rst_n,
   input  logic       io_clk_mouse,
   input  logic       io_data_mouse,
   output logic [7:0] o_byte,
   output logic       o_is_byte_readed,
   output logic       o_parity_err,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   // The counter holds TIMEOUT_CYCLES-2 on the cycle it steps to TIMEOUT_CYCLES-1.
   // The abort is taken on that step, so the error strobe lands exactly
   // TIMEOUT_CYCLES-1 cycles after the edge that took the last fall event.
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // Odd parity over data plus parity bit holds when the XOR of all nine bits is 1.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return (^data) ^ par;
   endfunction

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
   logic                   filt_clk_q, filt_clk_d;
   logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
   logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
   state_t                 state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic [7:0]             byte_q, byte_d;
   logic                   byte_stb_q, byte_stb_d;
   logic                   par_err_q, par_err_d;
   logic                   frm_err_q, frm_err_d;
   logic                   busy_q, busy_d;
   logic                   clk_s, data_s, fall_evt_s, tmo_hit_s;

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = dat_sync_q[SYNC_STAGES-1];

   // Synchronizer shift and PS/2 clock glitch filter; fall event is the filtered 1->0 step.
   always_comb begin
      clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], io_clk_mouse};
      dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], io_data_mouse};
      filt_clk_d = filt_clk_q;
      filt_cnt_d = {FW{1'b0}};
      if (clk_s != filt_clk_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_clk_d = clk_s;
            filt_cnt_d = {FW{1'b0}};
         end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
         end
      end else begin
         filt_cnt_d = {FW{1'b0}};
      end
      fall_evt_s = filt_clk_q & ~filt_clk_d;
   end

   // Inactivity timer: runs only inside a frame and restarts on every fall event.
   always_comb begin
      tmo_hit_s = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_LAST);
      if (fall_evt_s || (state_q == ST_IDLE) || tmo_hit_s) begin
         tmo_cnt_d = {TW{1'b0}};
      end else begin
         tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
   end

   // Frame FSM: advances on fall events; a timeout aborts unless a fall event coincides.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      byte_d     = byte_q;
      byte_stb_d = 1'b0;
      par_err_d  = 1'b0;
      frm_err_d  = 1'b0;
      if (fall_evt_s) begin
         case (state_q)
            ST_IDLE: begin
               if (!data_s) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
                  shift_d   = 8'h00;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_d = {data_s, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d   = ST_PARITY;
                  bit_cnt_d = 3'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            ST_PARITY: begin
               parity_d = data_s;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               if (!data_s) begin
                  frm_err_d = 1'b1;
               end else if (odd_parity_ok(shift_q, parity_q)) begin
                  byte_d     = shift_q;
                  byte_stb_d = 1'b1;
               end else begin
                  par_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (tmo_hit_s) begin
         frm_err_d = 1'b1;
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         shift_d   = 8'h00;
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; lines idle high so synchronizers and filter reset to 1.
   always_ff @(posedge i_driver_clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= {SYNC_STAGES{1'b1}};
         dat_sync_q <= {SYNC_STAGES{1'b1}};
         filt_clk_q <= 1'b1;
         filt_cnt_q <= {FW{1'b0}};
         tmo_cnt_q  <= {TW{1'b0}};
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         parity_q   <= 1'b0;
         byte_q     <= 8'h00;
         byte_stb_q <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         filt_clk_q <= filt_clk_d;
         filt_cnt_q <= filt_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         byte_q     <= byte_d;
         byte_stb_q <= byte_stb_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         busy_q     <= busy_d;
      end
   end

   assign o_byte           = byte_q;
   assign o_is_byte_readed = byte_stb_q;
   assign o_parity_err     = par_err_q;
   assign o_frame_err      = frm_err_q;
   assign o_busy           = busy_q;

endmodule
